nes_pad_responder: RTL



---
 rtl/nes_pad_responder.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/nes_pad_responder.sv
// nes_pad_responder
//
// Purpose:
//   Emulates the controller side of an NES-style latch/clock/data gamepad
//   link. Eight raw button levels are synchronized and debounced. While the
//   initiator holds latch high, the debounced levels are continuously
//   captured. After latch falls, the captured snapshot is shifted out
//   MSB-first and active-low, one bit per rising edge of the initiator's
//   serial clock. Useful for board-level loopback and as a stand-in pad.
//
// Ports:
//   PCLK            in   system clock, all logic on its rising edge
//   PRESERN         in   asynchronous active-low reset
//   buttons_raw     in   [7:0] raw button levels, 1 = pressed, asynchronous
//                        [7]=A [6]=B [5]=Select [4]=Start
//                        [3]=Up [2]=Down [1]=Left [0]=Right
//   latch           in   parallel-load strobe from initiator, active-high, async
//   clock           in   serial shift clock from initiator, async, rising-edge
//   data            out  serial button data, active-low (0 = pressed)
//   buttons_stable  out  [7:0] debounced button levels, 1 = pressed
//   frame_count     out  [CNT_W-1:0] completed latch pulses, wraps
//   overrun         out  sticky: clock edge seen after all 8 bits were sent
//   busy            out  high while loading or shifting
//
// Parameters:
//   DEBOUNCE_MAX    consecutive PCLK cycles a raw level must disagree with
//                   the stable level before the stable level flips (1..65535)
//   CNT_W           width of each debounce counter and of the frame counter

module nes_pad_responder #(
  parameter int unsigned DEBOUNCE_MAX = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             PCLK,
  input  logic             PRESERN,
  input  logic [7:0]       buttons_raw,
  input  logic             latch,
  input  logic             clock,
  output logic             data,
  output logic [7:0]       buttons_stable,
  output logic [CNT_W-1:0] frame_count,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_MAX - 1);

  state_t r_state;
  state_t w_nextState;

  logic [7:0]       r_rawMeta;
  logic [7:0]       r_rawSync;
  logic             r_latchMeta;
  logic             r_latchSync;
  logic             r_latchHist;
  logic             r_clockMeta;
  logic             r_clockSync;
  logic             r_clockHist;

  logic [CNT_W-1:0] r_dbCnt [8];
  logic [7:0]       r_stable;

  logic [7:0]       r_shiftReg;
  logic [2:0]       r_bitIdx;
  logic [CNT_W-1:0] r_frameCnt;
  logic             r_overrun;

  logic             w_latchRise;
  logic             w_latchFall;
  logic             w_clockRise;

  // Two-flop synchronizers for every asynchronous input, plus one history
  // flop on latch and clock so their edges can be detected in PCLK domain.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_rawMeta   <= '0;
      r_rawSync   <= '0;
      r_latchMeta <= 1'b0;
      r_latchSync <= 1'b0;
      r_latchHist <= 1'b0;
      r_clockMeta <= 1'b0;
      r_clockSync <= 1'b0;
      r_clockHist <= 1'b0;
    end else begin
      r_rawMeta   <= buttons_raw;
      r_rawSync   <= r_rawMeta;
      r_latchMeta <= latch;
      r_latchSync <= r_latchMeta;
      r_latchHist <= r_latchSync;
      r_clockMeta <= clock;
      r_clockSync <= r_clockMeta;
      r_clockHist <= r_clockSync;
    end
  end

  assign w_latchRise = r_latchSync & ~r_latchHist;
  assign w_latchFall = ~r_latchSync & r_latchHist;
  assign w_clockRise = r_clockSync & ~r_clockHist;

  // Per-bit debounce. Any cycle of agreement clears the counter, so only an
  // uninterrupted run of DEBOUNCE_MAX disagreeing cycles flips the stable
  // level. The counter is cleared on the flip, so it can never wrap.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_stable <= '0;
      for (int i = 0; i < 8; i++) begin
        r_dbCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (r_rawSync[i] == r_stable[i]) begin
          r_dbCnt[i] <= '0;
        end else if (r_dbCnt[i] == DB_LAST) begin
          r_stable[i] <= ~r_stable[i];
          r_dbCnt[i]  <= '0;
        end else begin
          r_dbCnt[i] <= r_dbCnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A latch rise restarts the transfer from any state and
  // takes priority over a clock rise in the same cycle.
  always_comb begin
    w_nextState = r_state;
    if (w_latchRise) begin
      w_nextState = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE:  w_nextState = ST_IDLE;
        ST_LOAD:  if (w_latchFall) w_nextState = ST_SHIFT;
        ST_SHIFT: if (w_clockRise && (r_bitIdx == 3'd7)) w_nextState = ST_DONE;
        ST_DONE:  w_nextState = ST_DONE;
        default:  w_nextState = ST_IDLE;
      endcase
    end
  end

  // Datapath: snapshot register, bit index, frame counter and overrun flag.
  // While latch is high the snapshot tracks buttons_stable every cycle so the
  // frame carries the level present when latch falls. Clock edges during LOAD
  // are ignored; a clock still high at latch fall never produces a rise.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_shiftReg <= '0;
      r_bitIdx   <= '0;
      r_frameCnt <= '0;
      r_overrun  <= 1'b0;
    end else if (w_latchRise) begin
      r_shiftReg <= r_stable;
      r_bitIdx   <= '0;
      r_overrun  <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_latchFall) begin
            r_bitIdx   <= '0;
            r_frameCnt <= r_frameCnt + CNT_W'(1);
          end else if (r_latchSync) begin
            r_shiftReg <= r_stable;
          end
        end
        ST_SHIFT: begin
          if (w_clockRise) begin
            r_shiftReg <= {r_shiftReg[6:0], 1'b0};
            r_bitIdx   <= r_bitIdx + 3'd1;
          end
        end
        ST_DONE: begin
          if (w_clockRise) begin
            r_overrun <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output logic. data is decoded from state so a reset forces it high
  // immediately. In LOAD the live debounced MSB is presented so the
  // initiator sees the first bit before latch falls.
  always_comb begin
    data = 1'b1;
    busy = 1'b0;
    case (r_state)
      ST_LOAD: begin
        data = ~r_stable[7];
        busy = 1'b1;
      end
      ST_SHIFT: begin
        data = ~r_shiftReg[7];
        busy = 1'b1;
      end
      default: begin
        data = 1'b1;
        busy = 1'b0;
      end
    endcase
  end

  assign buttons_stable = r_stable;
  assign frame_count    = r_frameCnt;
  assign overrun        = r_overrun;

endmodule
